seven_seg_scanner: RTL

Time-multiplexed driver for a 4-digit common-anode seven-segment display. It sits directly downstream of `clock_div`: the divided clock is sampled as a slow strobe in the `clock` domain and steps a digit-scan state machine. Each frame, the block latches a 16-bit hex value and per-digit decimal points, decodes one nibble per scan slot, and drives active-low anodes, segments and decimal point. All logic runs on the single system clock; `div_clock` is never used as a clock.

---
 rtl/seven_seg_scanner.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: time-multiplexed driver for a 4-digit common-anode
// seven-segment display. The div_clock input is synchronized and
// edge-detected in the clock domain. Each detected rising edge steps the
// digit scan. A new frame (value and dp_en) is latched at the start of every
// scan pass. Anodes, segments and decimal point are active-low and registered.
// Optional feature macro: SEVEN_SEG_LZ_BLANK_EN (leading-zero blanking).
module seven_seg_scanner #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        div_clock,
    input  logic [15:0] value,
    input  logic [3:0]  dp_en,
    input  logic        blank,
    output logic [3:0]  anode,
    output logic [6:0]  segs,
    output logic        dp,
    output logic [1:0]  digit_sel
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;
    logic                   synced;
    logic                   tick;

    state_t      state, state_n;
    logic [1:0]  sel_n;
    logic [15:0] frame_val, frame_val_n;
    logic [3:0]  frame_dp, frame_dp_n;

    logic [3:0]  nibble;
    logic [6:0]  decoded;
    logic [3:0]  lz_dark;
    logic        show;
    logic [3:0]  anode_n;
    logic [6:0]  segs_n;
    logic        dp_n;

    // Synchronizer chain plus previous-value flop for rising-edge detection
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], div_clock};
            prev <= synced;
        end
    end

    assign synced = sync[SYNC_STAGES-1];
    assign tick   = synced & ~prev;

    // Scan state register: FSM, current slot and latched frame
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            digit_sel <= 2'd0;
            frame_val <= '0;
            frame_dp  <= '0;
        end else begin
            state     <= state_n;
            digit_sel <= sel_n;
            frame_val <= frame_val_n;
            frame_dp  <= frame_dp_n;
        end
    end

    // Next-state logic: first tick starts scanning, each wrap relatches the frame
    always_comb begin
        state_n     = state;
        sel_n       = digit_sel;
        frame_val_n = frame_val;
        frame_dp_n  = frame_dp;
        case (state)
            IDLE: begin
                if (tick) begin
                    state_n     = SCAN;
                    frame_val_n = value;
                    frame_dp_n  = dp_en;
                end
            end
            SCAN: begin
                if (tick) begin
                    sel_n = digit_sel + 2'd1;
                    if (digit_sel == 2'd3) begin
                        frame_val_n = value;
                        frame_dp_n  = dp_en;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Nibble select and hex font decode for the current slot
    always_comb begin
        nibble = frame_val[3:0];
        case (digit_sel)
            2'd0: nibble = frame_val[3:0];
            2'd1: nibble = frame_val[7:4];
            2'd2: nibble = frame_val[11:8];
            2'd3: nibble = frame_val[15:12];
            default: nibble = frame_val[3:0];
        endcase
        decoded = 7'b1111111;
        case (nibble)
            4'h0: decoded = 7'b1000000;
            4'h1: decoded = 7'b1111001;
            4'h2: decoded = 7'b0100100;
            4'h3: decoded = 7'b0110000;
            4'h4: decoded = 7'b0011001;
            4'h5: decoded = 7'b0010010;
            4'h6: decoded = 7'b0000010;
            4'h7: decoded = 7'b1111000;
            4'h8: decoded = 7'b0000000;
            4'h9: decoded = 7'b0010000;
            4'hA: decoded = 7'b0001000;
            4'hB: decoded = 7'b0000011;
            4'hC: decoded = 7'b1000110;
            4'hD: decoded = 7'b0100001;
            4'hE: decoded = 7'b0000110;
            4'hF: decoded = 7'b0001110;
            default: decoded = 7'b1111111;
        endcase
    end

    // Leading-zero suppression mask; a digit with its decimal point set stays lit
    always_comb begin
        lz_dark = '0;
`ifdef SEVEN_SEG_LZ_BLANK_EN
        lz_dark[1] = (frame_val[15:4]  == 12'h000) && !frame_dp[1];
        lz_dark[2] = (frame_val[15:8]  == 8'h00)   && !frame_dp[2];
        lz_dark[3] = (frame_val[15:12] == 4'h0)    && !frame_dp[3];
`endif
    end

    // Pin values for the next edge: dark in IDLE, while blanked, or when suppressed
    always_comb begin
        show    = (state == SCAN) && !blank && !lz_dark[digit_sel];
        anode_n = '1;
        segs_n  = '1;
        dp_n    = 1'b1;
        if (show) begin
            anode_n = ~(4'b0001 << digit_sel);
            segs_n  = decoded;
            dp_n    = ~frame_dp[digit_sel];
        end
    end

    // Output register, refreshed every cycle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            anode <= '1;
            segs  <= '1;
            dp    <= 1'b1;
        end else begin
            anode <= anode_n;
            segs  <= segs_n;
            dp    <= dp_n;
        end
    end

endmodule
